vga_timing_pipe: RTL and testbench

- Parametrised successor to the VGA controller. Generates VGA horizontal/vertical timing and the pixel-request coordinates.
- Has a pixel-clock-enable divider, programmable sync polarity and configurable colour depth.
- Compensates for PIPE_LAT pixel ticks of downstream pixel-fetch latency: coordinates are issued early, and syncs and blanking are delayed to line up with the returned colour.
- Sits between the frame-buffer/pattern source and the DAC/pins.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_delay_line.sv | 48 ++++
 rtl/vga_timing_pipe.sv | 199 +++++++++++++++++++
 tb/tb_vga_timing_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing pipeline.
//   - Standard 640x480@60 mode constants used as parameter defaults.
//   - timing_bits_t: the per-pixel timing flags carried down the latency
//     compensation delay line.
//   - vga_total(): sums the four segments of a line or frame.
package vga_pkg;

  localparam int STD_H_ACTIVE = 640;
  localparam int STD_H_FRONT  = 16;
  localparam int STD_H_SYNC   = 96;
  localparam int STD_H_BACK   = 48;
  localparam int STD_V_ACTIVE = 480;
  localparam int STD_V_FRONT  = 10;
  localparam int STD_V_SYNC   = 2;
  localparam int STD_V_BACK   = 33;

  // hs/vs are raw (active-high) sync flags; polarity is applied at the output.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } timing_bits_t;

  function automatic int vga_total(input int active, input int front,
                                   input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register.
//   clk, rst_n : clock and synchronous active-low reset
//   ce         : advance strobe; the line only shifts when ce=1
//   d          : input word
//   q          : d delayed by DEPTH ce strobes (DEPTH=0 is a wire)
// Reset fills every stage with zeros, which for timing_bits_t means
// blank pixels with inactive raw sync.
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, ce};
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
      stage_d = stage_q;
      if (ce) begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with downstream pixel-fetch latency compensation.
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : run enable; 0 freezes all state and outputs
//   color_in     : {R,G,B} returned for the pixel requested PIPE_LAT ticks ago
//   pix_ce       : one-clk pixel tick strobe
//   req_x/req_y  : request coordinates (registered on the tick)
//   req_active   : request coordinate lies in the visible area
//   screenend    : pulse on the last request tick of a frame
//   frame_cnt    : completed-frame counter, wraps
//   hsync/vsync  : syncs delayed PIPE_LAT+1 ticks, polarity applied
//   active       : display enable delayed PIPE_LAT+1 ticks
//   red/green/blue : colour, forced to 0 outside the active area
// Line order is active, front porch, sync, back porch (same vertically).
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = STD_H_ACTIVE,
  parameter int H_FRONT    = STD_H_FRONT,
  parameter int H_SYNC     = STD_H_SYNC,
  parameter int H_BACK     = STD_H_BACK,
  parameter int V_ACTIVE   = STD_V_ACTIVE,
  parameter int V_FRONT    = STD_V_FRONT,
  parameter int V_SYNC     = STD_V_SYNC,
  parameter int V_BACK     = STD_V_BACK,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_LAT   = 2,
  parameter int COLOR_BITS = 8,
  parameter int CNT_W      = 10,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [3*COLOR_BITS-1:0] color_in,
  output logic                    pix_ce,
  output logic                    req_active,
  output logic [CNT_W-1:0]        req_x,
  output logic [CNT_W-1:0]        req_y,
  output logic                    screenend,
  output logic [15:0]             frame_cnt,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    active,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = CNT_W + 1;
  localparam int RGB_W   = 3 * COLOR_BITS;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_pipe: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h
    $error("vga_timing_pipe: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v
    $error("vga_timing_pipe: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_lat
    $error("vga_timing_pipe: PIPE_LAT must be in 0..15");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  // One extra bit so a boundary equal to 2^CNT_W still compares correctly.
  localparam logic [CW1-1:0]   H_ACT_B  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0]   H_SYN_LO = CW1'(H_ACTIVE + H_FRONT);
  localparam logic [CW1-1:0]   H_SYN_HI = CW1'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW1-1:0]   V_ACT_B  = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0]   V_SYN_LO = CW1'(V_ACTIVE + V_FRONT);
  localparam logic [CW1-1:0]   V_SYN_HI = CW1'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             tick;
  logic             last_tick;

  logic [CNT_W-1:0] req_x_p0_q, req_x_p0_d;
  logic [CNT_W-1:0] req_y_p0_q, req_y_p0_d;
  timing_bits_t     tbits_p0_q, tbits_p0_d;
  timing_bits_t     tbits_dly;

  logic             active_p1_q, active_p1_d;
  logic             hsync_p1_q, hsync_p1_d;
  logic             vsync_p1_q, vsync_p1_d;
  logic [RGB_W-1:0] rgb_p1_q, rgb_p1_d;

  always_comb begin
    // rst_n gates the strobe so nothing ticks while reset is held, even with CLK_DIV=1.
    tick        = rst_n & en & (div_q == DIV_LAST);
    last_tick   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    div_d       = div_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    req_x_p0_d  = req_x_p0_q;
    req_y_p0_d  = req_y_p0_q;
    tbits_p0_d  = tbits_p0_q;
    active_p1_d = active_p1_q;
    hsync_p1_d  = hsync_p1_q;
    vsync_p1_d  = vsync_p1_q;
    rgb_p1_d    = rgb_p1_q;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      if (last_tick) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end

      // ---- stage p0: request coordinates and raw timing flags ----
      req_x_p0_d        = h_cnt_q;
      req_y_p0_d        = v_cnt_q;
      tbits_p0_d.active = ({1'b0, h_cnt_q} < H_ACT_B) && ({1'b0, v_cnt_q} < V_ACT_B);
      tbits_p0_d.hs     = ({1'b0, h_cnt_q} >= H_SYN_LO) && ({1'b0, h_cnt_q} < H_SYN_HI);
      tbits_p0_d.vs     = ({1'b0, v_cnt_q} >= V_SYN_LO) && ({1'b0, v_cnt_q} < V_SYN_HI);

      // ---- stage p1: delayed flags meet the returned colour ----
      active_p1_d = tbits_dly.active;
      hsync_p1_d  = tbits_dly.hs ~^ HSYNC_POL;
      vsync_p1_d  = tbits_dly.vs ~^ VSYNC_POL;
      rgb_p1_d    = tbits_dly.active ? color_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      tbits_p0_q  <= '0;
      active_p1_q <= 1'b0;
      hsync_p1_q  <= ~HSYNC_POL;
      vsync_p1_q  <= ~VSYNC_POL;
      rgb_p1_q    <= '0;
    end else begin
      div_q       <= div_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tbits_p0_q  <= tbits_p0_d;
      active_p1_q <= active_p1_d;
      hsync_p1_q  <= hsync_p1_d;
      vsync_p1_q  <= vsync_p1_d;
      rgb_p1_q    <= rgb_p1_d;
    end
  end

  // Coordinates carry no control meaning on their own; req_active qualifies them.
  always_ff @(posedge clk) begin
    req_x_p0_q <= req_x_p0_d;
    req_y_p0_q <= req_y_p0_d;
  end

  // ---- p0 -> p1: PIPE_LAT tick delay matching the pixel-fetch latency ----
  vga_delay_line #(
    .DEPTH(PIPE_LAT),
    .WIDTH($bits(timing_bits_t))
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (tick),
    .d    (tbits_p0_q),
    .q    (tbits_dly)
  );

  assign pix_ce     = tick;
  assign screenend  = tick & last_tick;
  assign frame_cnt  = frame_cnt_q;
  assign req_x      = req_x_p0_q;
  assign req_y      = req_y_p0_q;
  assign req_active = tbits_p0_q.active;
  assign active     = active_p1_q;
  assign hsync      = hsync_p1_q;
  assign vsync      = vsync_p1_q;
  assign red        = rgb_p1_q[RGB_W-1:2*COLOR_BITS];
  assign green      = rgb_p1_q[2*COLOR_BITS-1:COLOR_BITS];
  assign blue       = rgb_p1_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: small 32x22 mode, CLK_DIV=4.
// Main instance: PIPE_LAT=2, negative syncs. Second instance: PIPE_LAT=0,
// positive hsync. The driver predicts every clock edge and queues the
// expected post-edge outputs; the monitor pops and compares.
module tb_vga_timing_pipe;

  localparam int HA = 20, HF = 3, HS = 4, HB = 5;
  localparam int VA = 10, VF = 3, VS = 4, VB = 5;
  localparam int HT = 32, VT = 22, DIV = 4, LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] color_in;

  logic        pix_ce, req_active, screenend, hsync, vsync, active;
  logic [9:0]  req_x, req_y;
  logic [15:0] frame_cnt;
  logic [7:0]  red, green, blue;

  logic        unused_pix_ce_b, unused_req_active_b, unused_screenend_b;
  logic [9:0]  unused_req_x_b, unused_req_y_b;
  logic [15:0] unused_frame_cnt_b;
  logic [7:0]  unused_green_b, unused_blue_b;
  logic        hsync_b, vsync_b, active_b;
  logic [7:0]  red_b;

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .PIPE_LAT(LAT), .COLOR_BITS(8), .CNT_W(10),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .color_in(color_in),
    .pix_ce(pix_ce), .req_active(req_active), .req_x(req_x), .req_y(req_y),
    .screenend(screenend), .frame_cnt(frame_cnt), .hsync(hsync), .vsync(vsync),
    .active(active), .red(red), .green(green), .blue(blue)
  );

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .PIPE_LAT(0), .COLOR_BITS(8), .CNT_W(10),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .color_in(color_in),
    .pix_ce(unused_pix_ce_b), .req_active(unused_req_active_b),
    .req_x(unused_req_x_b), .req_y(unused_req_y_b),
    .screenend(unused_screenend_b), .frame_cnt(unused_frame_cnt_b),
    .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
    .red(red_b), .green(unused_green_b), .blue(unused_blue_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         tick;
    bit         se;
    bit         chk_xy;
    logic [9:0] x, y;
    logic       ract, act, hs, vs;
    logic [7:0] r, g, b;
    logic [15:0] fc;
    logic       act_b, hs_b, vs_b;
    logic [7:0] r_b;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (driver side) ----------------
  int m_div = 0, m_h = 0, m_v = 0, m_n = 0, m_frame = 0;
  int rst_cyc = 0;

  // {active, raw hs, raw vs} of a linear position within the frame
  function automatic logic [2:0] pos_bits(input int p);
    int ph, pv;
    ph = p % HT;
    pv = p / HT;
    return {(ph < HA) && (pv < VA),
            (ph >= HA + HF) && (ph < HA + HF + HS),
            (pv >= VA + VF) && (pv < VA + VF + VS)};
  endfunction

  function automatic logic [23:0] col_for();
    if (m_frame == 1) return 24'hFFFFFF;
    return {8'(m_n), 8'(m_n * 7), 8'hC3 ^ 8'(m_n)};
  endfunction

  function automatic exp_t make_tick(input logic [23:0] col);
    exp_t e;
    int t, p;
    logic [2:0] pb;
    e.cyc = cyc; e.tick = 1'b1; e.chk_xy = 1'b1;
    e.se = (m_h == HT - 1) && (m_v == VT - 1);
    e.x = 10'(m_h); e.y = 10'(m_v);
    e.ract = (m_h < HA) && (m_v < VA);
    e.fc = e.se ? 16'(m_frame + 1) : 16'(m_frame);
    t = m_v * HT + m_h;
    if (m_n >= LAT + 1) begin
      p = (t - (LAT + 1) + HT * VT) % (HT * VT);
      pb = pos_bits(p);
      e.act = pb[2]; e.hs = ~pb[1]; e.vs = ~pb[0];
      {e.r, e.g, e.b} = pb[2] ? col : 24'h0;
    end else begin
      e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1; {e.r, e.g, e.b} = 24'h0;
    end
    if (m_n >= 1) begin
      p = (t - 1 + HT * VT) % (HT * VT);
      pb = pos_bits(p);
      e.act_b = pb[2]; e.hs_b = pb[1]; e.vs_b = ~pb[0];
      e.r_b = pb[2] ? col[23:16] : 8'h0;
    end else begin
      e.act_b = 1'b0; e.hs_b = 1'b0; e.vs_b = 1'b1; e.r_b = 8'h0;
    end
    return e;
  endfunction

  function automatic exp_t make_reset();
    exp_t e;
    e.cyc = cyc; e.tick = 1'b0; e.se = 1'b0; e.chk_xy = 1'b0;
    e.x = '0; e.y = '0; e.ract = 1'b0; e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    {e.r, e.g, e.b} = 24'h0; e.fc = 16'h0;
    e.act_b = 1'b0; e.hs_b = 1'b0; e.vs_b = 1'b1; e.r_b = 8'h0;
    return e;
  endfunction

  // Drive one clock: set inputs, queue what the next edge must produce, advance the model.
  task automatic drive(input bit r_n, input bit e_in);
    logic [23:0] col;
    bit ce;
    col = col_for();
    rst_n = r_n; en = e_in; color_in = col;
    ce = r_n && e_in && (m_div == DIV - 1);
    if (!r_n) sb.push_back(make_reset());
    else if (ce) sb.push_back(make_tick(col));
    @(posedge clk); #1;
    if (!r_n) begin
      m_div = 0; m_h = 0; m_v = 0; m_n = 0; m_frame = 0;
    end else if (e_in) begin
      if (ce) begin
        if (m_h == HT - 1 && m_v == VT - 1) m_frame++;
        m_n++;
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
      end
      m_div = (m_div == DIV - 1) ? 0 : m_div + 1;
    end
  endtask

  task automatic run_until(input int fr, input int vv, input int hh);
    for (int i = 0; i < 20000; i++) begin
      if (m_frame == fr && m_v == vv && m_h == hh && m_div == 0) return;
      drive(1'b1, 1'b1);
    end
    chk("run_until_timeout", 32'(m_frame), 32'(fr));
  endtask

  // ---------------- monitor ----------------
  exp_t pend, refe;
  bit   pend_vld = 1'b0, ref_vld = 1'b0;
  int   se_cyc[$];
  int   fr_act[$], fr_hl[$], fr_vl[$];
  int   cnt_act = 0, cnt_hl = 0, cnt_vl = 0;

  task automatic compare_post(input exp_t e);
    if (e.chk_xy) begin
      chk("req_x", 32'(req_x), 32'(e.x));
      chk("req_y", 32'(req_y), 32'(e.y));
    end
    chk("req_active", 32'(req_active), 32'(e.ract));
    chk("active",     32'(active),     32'(e.act));
    chk("hsync",      32'(hsync),      32'(e.hs));
    chk("vsync",      32'(vsync),      32'(e.vs));
    chk("red",        32'(red),        32'(e.r));
    chk("green",      32'(green),      32'(e.g));
    chk("blue",       32'(blue),       32'(e.b));
    chk("frame_cnt",  32'(frame_cnt),  32'(e.fc));
    chk("active_lat0", 32'(active_b),  32'(e.act_b));
    chk("hsync_pos",  32'(hsync_b),    32'(e.hs_b));
    chk("vsync_lat0", 32'(vsync_b),    32'(e.vs_b));
    chk("red_lat0",   32'(red_b),      32'(e.r_b));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (pend_vld) begin
        compare_post(pend);
        if (pend.tick) begin
          if (active === 1'b1) cnt_act++;
          if (hsync === 1'b0) cnt_hl++;
          if (vsync === 1'b0) cnt_vl++;
        end
        refe = pend; ref_vld = 1'b1; pend_vld = 1'b0;
      end else if (ref_vld) begin
        compare_post(refe);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("edge_order", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        pend = sb.pop_front();
        pend_vld = 1'b1;
        chk("pix_ce", 32'(pix_ce), 32'(pend.tick));
        chk("screenend", 32'(screenend), 32'(pend.se));
      end else begin
        chk("pix_ce_idle", 32'(pix_ce), 32'd0);
        chk("screenend_idle", 32'(screenend), 32'd0);
      end
      if (screenend === 1'b1) begin
        se_cyc.push_back(cyc);
        fr_act.push_back(cnt_act); fr_hl.push_back(cnt_hl); fr_vl.push_back(cnt_vl);
        cnt_act = 0; cnt_hl = 0; cnt_vl = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; color_in = 24'h0;
    @(posedge clk); #1;
    repeat (3) drive(1'b0, 1'b1);
    // frames 0 and 1 run freely; stall inside frame 2 right after req_x=7
    run_until(2, 5, 8);
    repeat (50) drive(1'b1, 1'b0);
    // reset for one clock in the middle of line 12 of frame 3
    run_until(3, 12, 3);
    rst_cyc = cyc;
    drive(1'b0, 1'b1);
    run_until(1, 0, 4);
    repeat (6) drive(1'b1, 1'b0);
    @(negedge clk); #1;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("screenend_count", 32'(se_cyc.size()), 32'd4);
    if (se_cyc.size() >= 4) begin
      chk("frame_period", 32'(se_cyc[1] - se_cyc[0]), 32'd2816);
      chk("frame_period_en_gap", 32'(se_cyc[2] - se_cyc[1]), 32'd2866);
      chk("reset_to_screenend", 32'(se_cyc[3] - rst_cyc), 32'd2816);
      chk("active_ticks_f1", 32'(fr_act[1]), 32'd200);
      chk("hsync_low_ticks_f1", 32'(fr_hl[1]), 32'd88);
      chk("vsync_low_ticks_f1", 32'(fr_vl[1]), 32'd128);
      chk("active_ticks_f2", 32'(fr_act[2]), 32'd200);
      chk("hsync_low_ticks_f2", 32'(fr_hl[2]), 32'd88);
      chk("vsync_low_ticks_f2", 32'(fr_vl[2]), 32'd128);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
